// File: rtl/iomem_initiator_if.sv
// iomem_initiator_if: command/response handshake and iomem bus signals of the initiator.
interface iomem_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready, iomem_ready, iomem_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready, iomem_ready, iomem_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
  );
endinterface

// File: rtl/iomem_initiator.sv
// iomem_initiator: turns one command at a time into an iomem bus transaction with timeout,
// and holds the response until the consumer takes it.
module iomem_initiator #(
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              resetn,
  iomem_initiator_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
  state_t        state;
  logic [CW-1:0] cnt;
  assign bus.cmd_ready = state == IDLE;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.iomem_valid <= 1'b0;
      bus.iomem_wstrb <= 4'b0000;
      bus.iomem_addr  <= '0;
      bus.iomem_wdata <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_error   <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          bus.iomem_addr  <= bus.cmd_addr;
          bus.iomem_wdata <= bus.cmd_wdata;
          bus.iomem_wstrb <= bus.cmd_write ? bus.cmd_wstrb : 4'b0000;
          bus.iomem_valid <= 1'b1;
          bus.busy        <= 1'b1;
          cnt             <= '0;
          state           <= BUSY;
        end
        BUSY: if (bus.iomem_ready) begin
          // a zero strobe means the bus saw a read, so the data is meaningful
          bus.iomem_valid <= 1'b0;
          bus.rsp_rdata   <= (bus.iomem_wstrb == 4'b0000) ? bus.iomem_rdata : '0;
          bus.rsp_error   <= 1'b0;
          bus.rsp_valid   <= 1'b1;
          state           <= RESP;
        end else if (TIMEOUT != 0) begin
          if (cnt == LAST) begin
            bus.iomem_valid <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_error   <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end else cnt <= cnt + 1'b1;
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/iomem_initiator.md
IOMEM_INITIATOR -- requirements
Module: iomem_initiator

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles iomem_valid is held without iomem_ready; 0 disables timeout.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  32  byte address.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 cmd_wstrb  input  4  byte-lane write enables.
REQ-010 rsp_valid  output  1  response held for consumer.
REQ-011 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and timeouts.
REQ-013 rsp_error  output  1  1 = transaction timed out.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 iomem_valid  output  1  bus request, registered.
REQ-016 iomem_ready  input  1  responder completion (OR of all responders).
REQ-017 iomem_wstrb  output  4  bus strobes; 4'b0000 = read.
REQ-018 iomem_addr  output  32  bus address, registered.
REQ-019 iomem_wdata  output  32  bus write data, registered.
REQ-020 iomem_rdata  input  32  responder read data, valid only while iomem_ready is high.

Function
REQ-021 FSM states: IDLE, BUSY, RESP; cmd_ready = (state == IDLE), combinational from state only.
REQ-022 IDLE, cmd_valid high: latch addr, wdata and wstrb (cmd_write ? cmd_wstrb : 4'b0000), clear timeout counter, set iomem_valid, go to BUSY on the same edge.
REQ-023 A write with cmd_wstrb == 4'b0000 is issued on the bus as a read and reported as a read.
REQ-024 BUSY: iomem_valid, iomem_addr, iomem_wdata and iomem_wstrb stay stable until completion.
REQ-025 BUSY, iomem_ready high: clear iomem_valid; capture rsp_rdata = iomem_rdata for reads, 0 for writes; set rsp_error = 0 and rsp_valid = 1; go to RESP on that edge.
REQ-026 BUSY, iomem_ready low, TIMEOUT != 0: increment counter; when counter == TIMEOUT-1 on an edge, clear iomem_valid, set rsp_rdata = 0, rsp_error = 1 and rsp_valid = 1, and go to RESP. iomem_valid is high for exactly TIMEOUT cycles.
REQ-027 iomem_ready and timeout on the same edge: ready wins, rsp_error = 0.
REQ-028 Timeout counter width is $clog2(TIMEOUT+1), minimum 1; it never wraps.
REQ-029 RESP: rsp_valid, rsp_rdata and rsp_error stay stable until rsp_ready is high; on that edge clear rsp_valid and go to IDLE. No new command is accepted in the same cycle.
REQ-030 iomem_ready is ignored in IDLE and RESP; a late ready after a timeout has no effect.
REQ-031 Latency: command accepted at edge N, iomem_valid high from N; with a responder asserting ready one cycle after valid, rsp_valid is high from edge N+2.
REQ-032 Throughput: at most one outstanding transaction; with rsp_ready tied high, back-to-back commands are spaced at least 3 cycles apart.

Reset
REQ-033 resetn low asynchronously forces state = IDLE, and forces iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, rsp_valid, rsp_rdata, rsp_error, busy and the timeout counter to 0.
REQ-034 Reset during BUSY or RESP abandons the transaction and produces no response after release.
REQ-035 After release, cmd_ready is high on the first edge.

Verification
REQ-036 Read 0x03000000 from a gpio-style responder (ready 1 cycle after valid, rdata 0x000000A5) -> iomem_wstrb = 0, rsp_rdata = 0x000000A5, rsp_error = 0, rsp_valid at N+2.
REQ-037 Write 0x40000004, wdata 0x12345678, wstrb 4'b0011 -> bus shows the same values stable until ready; rsp_rdata = 0, rsp_error = 0.
REQ-038 TIMEOUT = 4, no responder -> iomem_valid high for exactly 4 cycles, rsp_error = 1, rsp_rdata = 0; a ready pulse 2 cycles later is ignored.
REQ-039 TIMEOUT = 4, ready arrives on the 4th cycle -> rsp_error = 0, rdata captured.
REQ-040 rsp_ready held low for 10 cycles, cmd_valid held high -> response stable, cmd_ready = 0, no bus activity; accepted 1 cycle after rsp_ready.
REQ-041 resetn pulsed low mid-BUSY -> iomem_valid = 0 immediately (asynchronously), no rsp_valid after release, cmd_ready = 1.
